// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - shared encodings for the universal shift register
package usr_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic DIR_R = 1'b0;
  localparam logic DIR_L = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/burst_counter.sv
// rtl/burst_counter.sv - loadable down-counter that tracks remaining burst shifts
module burst_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Saturates at zero: a stray decrement never wraps the count.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign last  = (count_q == CNT_W'(1));

endmodule

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - WIDTH-bit universal shift register with multi-cycle burst shifter
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic             start,
  input  logic [CNT_W-1:0] nshift,
  input  logic             dir,
  input  logic             fill,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             done_q, done_d;
  logic             dir_q, dir_d;
  logic             fill_q, fill_d;

  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt;
  logic             cnt_last;

  burst_counter #(
    .CNT_W(CNT_W)
  ) u_burst_counter (
    .clk     (clk),
    .rst     (rst),
    .load    (cnt_load),
    .load_val(nshift),
    .dec     (cnt_dec),
    .count   (cnt),
    .last    (cnt_last)
  );

  // With en low nothing moves, so done is stretched until the next enabled edge.
  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    done_d   = done_q;
    dir_d    = dir_q;
    fill_d   = fill_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    if (en) begin
      done_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (nshift != '0) begin
              cnt_load = 1'b1;
              dir_d    = dir;
              fill_d   = fill;
              state_d  = ST_SHIFT;
            end else begin
              done_d = 1'b1;
            end
          end else begin
            case (mode)
              MODE_SHR:  q_d = {sin_r, q_q[WIDTH-1:1]};
              MODE_SHL:  q_d = {q_q[WIDTH-2:0], sin_l};
              MODE_LOAD: q_d = d;
              default:   q_d = q_q;
            endcase
          end
        end
        ST_SHIFT: begin
          // A zero count here can only come from corruption; fall back to IDLE.
          if (cnt != '0) begin
            if (dir_q == DIR_L) begin
              q_d = {q_q[WIDTH-2:0], fill_q};
            end else begin
              q_d = {fill_q, q_q[WIDTH-1:1]};
            end
            cnt_dec = 1'b1;
            if (cnt_last) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      done_q  <= 1'b0;
      dir_q   <= DIR_R;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      done_q  <= done_d;
      dir_q   <= dir_d;
      fill_q  <= fill_d;
    end
  end

  assign q      = q_q;
  assign sout_r = q_q[0];
  assign sout_l = q_q[WIDTH-1];
  assign busy   = (state_q == ST_SHIFT);
  assign done   = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - scoreboard bench for univ_shift_reg against a behavioural model
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [7:0] d;
  logic       sin_r, sin_l;
  logic       start;
  logic [3:0] nshift;
  logic       dir, fill;
  logic [7:0] q;
  logic       sout_r, sout_l, busy, done;

  univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
    .sin_r(sin_r), .sin_l(sin_l), .start(start), .nshift(nshift),
    .dir(dir), .fill(fill), .q(q), .sout_r(sout_r), .sout_l(sout_l),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference model: remaining shifts as a plain integer.
  logic [7:0] m_q    = 8'h00;
  int         m_rem  = 0;
  logic       m_dir  = 1'b0;
  logic       m_fill = 1'b0;
  logic       m_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
  endtask

  task automatic model_reset();
    m_q = 8'h00; m_rem = 0; m_done = 1'b0; m_dir = 1'b0; m_fill = 1'b0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else if (en) begin
      m_done = 1'b0;
      if (m_rem > 0) begin
        if (m_dir) m_q = (m_q << 1) | {7'd0, m_fill};
        else       m_q = (m_q >> 1) | {m_fill, 7'd0};
        m_rem--;
        if (m_rem == 0) m_done = 1'b1;
      end else if (start) begin
        if (nshift != 0) begin
          m_rem = int'(nshift); m_dir = dir; m_fill = fill;
        end else begin
          m_done = 1'b1;
        end
      end else begin
        case (mode)
          2'b01: m_q = (m_q >> 1) | {sin_r, 7'd0};
          2'b10: m_q = (m_q << 1) | {7'd0, sin_l};
          2'b11: m_q = d;
          default: ;
        endcase
      end
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    model_edge();
    e.q = m_q; e.busy = (m_rem > 0); e.done = m_done;
    exp_q.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic burst(input logic [3:0] n, input logic bdir, input logic bfill);
    start = 1'b1; nshift = n; dir = bdir; fill = bfill;
    step();
    start = 1'b0;
  endtask

  task automatic load(input logic [7:0] v);
    mode = 2'b11; d = v;
    step();
    mode = 2'b00;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("q", 32'(q), 32'(e.q));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("done", 32'(done), 32'(e.done));
        chk("sout", 32'({sout_l, sout_r}), 32'({e.q[7], e.q[0]}));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    rst = 1'b1; en = 1'b0; mode = 2'b00; d = 8'h00; sin_r = 1'b0; sin_l = 1'b0;
    start = 1'b0; nshift = 4'd0; dir = 1'b0; fill = 1'b0;
    #3;
    chk("reset_q", 32'(q), 32'h00);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    step();
    rst = 1'b0; en = 1'b1;

    // Mode operations
    load(8'hA5);
    mode = 2'b01; sin_r = 1'b1; step();
    load(8'hA5);
    mode = 2'b10; sin_l = 1'b0; step();
    mode = 2'b00; steps(3);
    en = 1'b0; mode = 2'b11; d = 8'hFF; steps(2);
    en = 1'b1; mode = 2'b00;

    // Burst left with ignored load request
    load(8'h81);
    burst(4'd3, 1'b1, 1'b0);
    mode = 2'b11; d = 8'hFF; steps(3);
    mode = 2'b00; steps(2);

    // Zero-length burst and long right burst
    burst(4'd0, 1'b0, 1'b0);
    steps(2);
    load(8'h00);
    burst(4'd10, 1'b0, 1'b1);
    steps(11);

    // Pause mid-burst
    load(8'h01);
    burst(4'd4, 1'b1, 1'b0);
    step();
    en = 1'b0; steps(2);
    en = 1'b1; steps(4);

    // Async reset mid-burst
    load(8'h01);
    burst(4'd4, 1'b1, 1'b0);
    step();
    rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst_q", 32'(q), 32'h00);
    chk("async_rst_busy", 32'(busy), 32'h0);
    chk("async_rst_done", 32'(done), 32'h0);
    step();
    rst = 1'b0; steps(2);

    // Back-to-back bursts
    load(8'h81);
    burst(4'd2, 1'b0, 1'b1);
    steps(2);
    burst(4'd2, 1'b1, 1'b0);
    steps(3);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst    = ($urandom_range(0, 149) == 0);
      en     = ($urandom_range(0, 7) != 0);
      mode   = 2'($urandom_range(0, 3));
      d      = 8'($urandom);
      sin_r  = 1'($urandom);
      sin_l  = 1'($urandom);
      start  = ($urandom_range(0, 5) == 0);
      nshift = 4'($urandom_range(0, 15));
      dir    = 1'($urandom);
      fill   = 1'($urandom);
      step();
    end
    rst = 1'b0; en = 1'b1; start = 1'b0; mode = 2'b00;
    steps(20);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) chk("drain", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
